// File: rtl/inv_seq_checker.sv
// inv_seq_checker: walks a run of consecutive operands through the modular-inverse unit and reports each result.
// Per issued operand: 1 + unit latency (+W when INV_SEQ_CHECK_EN) + 2 cycles; no backpressure, inv_done wait bounded by TIMEOUT (0 = unbounded).
module inv_seq_checker #(
  parameter int unsigned  W       = 64,
  parameter logic [W-1:0] P       = 64'hFFFFFFFF00000001,
  parameter int unsigned  TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] first_val,
  input  logic [15:0]  count,
  output logic         busy,
  output logic         inv_enable,
  output logic [W-1:0] inv_t,
  input  logic [W-1:0] inv_result,
  input  logic         inv_done,
  output logic         res_valid,
  output logic [W-1:0] res_operand,
  output logic [W-1:0] res_value,
  output logic         res_ok,
  output logic         res_skip,
  output logic         res_timeout,
  output logic [15:0]  err_count,
  output logic         all_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_REPORT, S_NEXT, S_DONE
  } state_t;

  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT) - 32'd1;

  state_t       state;
  logic [W-1:0] operand;
  logic [W-1:0] op_inc;
  logic [15:0]  remaining;
  logic [31:0]  wait_cnt;

  assign op_inc = (operand == P - W'(1)) ? '0 : operand + W'(1);
  assign inv_t  = operand;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef INV_SEQ_CHECK_EN
  localparam int         CW = $clog2(W + 1);
  localparam logic [W:0] PX = {1'b0, P};

  logic [W-1:0]  acc;
  logic [W-1:0]  acc_nxt;
  logic [W-1:0]  mul_b;
  logic [W-1:0]  cap;
  logic [CW-1:0] step;
  logic [W:0]    dbl;
  logic [W:0]    sum;

  // One MSB-first double-and-add step; both operands stay below P so one subtract suffices.
  always_comb begin
    dbl = {acc, 1'b0};
    if (dbl >= PX) dbl = dbl - PX;
    sum = dbl + {1'b0, operand};
    if (sum >= PX) sum = sum - PX;
    acc_nxt = mul_b[W-1] ? sum[W-1:0] : dbl[W-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      operand     <= '0;
      remaining   <= '0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      inv_enable  <= 1'b0;
      res_valid   <= 1'b0;
      res_operand <= '0;
      res_value   <= '0;
      res_ok      <= 1'b0;
      res_skip    <= 1'b0;
      res_timeout <= 1'b0;
      err_count   <= '0;
      all_done    <= 1'b0;
`ifdef INV_SEQ_CHECK_EN
      acc         <= '0;
      mul_b       <= '0;
      cap         <= '0;
      step        <= '0;
`endif
    end else begin
      inv_enable <= 1'b0;
      res_valid  <= 1'b0;
      all_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            operand   <= first_val;
            remaining <= count;
            err_count <= '0;
            if (count == 16'd0) begin
              state    <= S_DONE;
              all_done <= 1'b1;
            end else begin
              state      <= S_ISSUE;
              busy       <= 1'b1;
              inv_enable <= (first_val != '0);
            end
          end
        end
        S_ISSUE: begin
          // inv_done deliberately ignored here: a level left high by the previous operand is stale.
          if (operand == '0) begin
            state       <= S_REPORT;
            res_valid   <= 1'b1;
            res_operand <= operand;
            res_value   <= '0;
            res_ok      <= 1'b0;
            res_skip    <= 1'b1;
            res_timeout <= 1'b0;
          end else begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (inv_done) begin
`ifdef INV_SEQ_CHECK_EN
            state <= S_CHECK;
            cap   <= inv_result;
            mul_b <= (inv_result >= P) ? inv_result - P : inv_result;
            acc   <= '0;
            step  <= '0;
`else
            state       <= S_REPORT;
            res_valid   <= 1'b1;
            res_operand <= operand;
            res_value   <= inv_result;
            res_ok      <= 1'b1;
            res_skip    <= 1'b0;
            res_timeout <= 1'b0;
`endif
          end else if (TMO_EN && wait_cnt == TMO_LAST) begin
            state       <= S_REPORT;
            res_valid   <= 1'b1;
            res_operand <= operand;
            res_value   <= '0;
            res_ok      <= 1'b0;
            res_skip    <= 1'b0;
            res_timeout <= 1'b1;
            err_count   <= sat_inc(err_count);
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
`ifdef INV_SEQ_CHECK_EN
        S_CHECK: begin
          acc   <= acc_nxt;
          mul_b <= mul_b << 1;
          step  <= step + CW'(1);
          if (step == CW'(W - 1)) begin
            state       <= S_REPORT;
            res_valid   <= 1'b1;
            res_operand <= operand;
            res_value   <= cap;
            res_ok      <= (acc_nxt == W'(1));
            res_skip    <= 1'b0;
            res_timeout <= 1'b0;
            if (acc_nxt != W'(1)) err_count <= sat_inc(err_count);
          end
        end
`endif
        S_REPORT: state <= S_NEXT;
        S_NEXT: begin
          operand   <= op_inc;
          remaining <= remaining - 16'd1;
          if (remaining != 16'd1) begin
            state      <= S_ISSUE;
            inv_enable <= (op_inc != '0);
          end else begin
            state    <= S_DONE;
            busy     <= 1'b0;
            all_done <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_seq_checker.sv
// Randomised bench for inv_seq_checker (W=8, P=97, TIMEOUT=100) with a responder and a queue-based reference model.
module tb_inv_seq_checker;
  localparam int W   = 8;
  localparam int PV  = 97;
  localparam int TMO = 100;
`ifdef INV_SEQ_CHECK_EN
  localparam int CHK = W;
  localparam int FAULT_ERR = 1;
`else
  localparam int CHK = 0;
  localparam int FAULT_ERR = 0;
`endif

  typedef struct {
    int op;
    int val;
    bit ok;
    bit skip;
    bit tmo;
    int lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] first_val;
  logic [15:0]  count;
  logic         busy, inv_enable, inv_done;
  logic [W-1:0] inv_t, inv_result;
  logic         res_valid, res_ok, res_skip, res_timeout, all_done;
  logic [W-1:0] res_operand, res_value;
  logic [15:0]  err_count;

  always #5 clk = ~clk;

  inv_seq_checker #(.W(W), .P(8'd97), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .first_val(first_val), .count(count),
    .busy(busy), .inv_enable(inv_enable), .inv_t(inv_t),
    .inv_result(inv_result), .inv_done(inv_done),
    .res_valid(res_valid), .res_operand(res_operand), .res_value(res_value),
    .res_ok(res_ok), .res_skip(res_skip), .res_timeout(res_timeout),
    .err_count(err_count), .all_done(all_done)
  );

  int           vectors = 0;
  int           miscompares = 0;
  int           model_err = 0;
  int           done_seen = 0;
  bit           outst = 0;
  exp_t         exp_q[$];
  logic [W-1:0] issue_q[$];
  logic [W-1:0] resp_tab[0:255];
  int           rsp_lat = 1;
  bit           rsp_never = 0;
  bit           rsp_stale = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int inv_mod(input int a);
    for (int x = 1; x < PV; x++) if ((a * x) % PV == 1) return x;
    return 0;
  endfunction

  task automatic fill_good();
    for (int i = 0; i < 256; i++) resp_tab[i] = W'(inv_mod(i % PV));
  endtask

  task automatic fill_random();
    fill_good();
    for (int i = 0; i < PV; i++)
      if ($urandom_range(0, 3) == 0) resp_tab[i] = W'($urandom_range(0, 255));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_inv_enable"}, inv_enable, 0);
    check({tag, "_inv_t"}, inv_t, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_operand"}, res_operand, 0);
    check({tag, "_res_value"}, res_value, 0);
    check({tag, "_res_ok"}, res_ok, 0);
    check({tag, "_res_skip"}, res_skip, 0);
    check({tag, "_res_timeout"}, res_timeout, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_all_done"}, all_done, 0);
  endtask

  // Responder: answers each inv_enable after rsp_lat cycles with resp_tab[operand].
  initial begin
    int cnt;
    bit pend;
    bit drop;
    logic [W-1:0] op;
    cnt = 0; pend = 0; drop = 0; op = '0;
    inv_done = 1'b0;
    inv_result = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0; drop = 0; inv_done = 1'b0;
      end else begin
        if (!rsp_stale || drop) begin
          inv_done = 1'b0;
          drop = 0;
        end
        if (inv_enable) begin
          pend = !rsp_never;
          cnt = rsp_lat;
          op = inv_t;
          drop = 1;
        end else if (pend) begin
          cnt--;
          if (cnt == 0) begin
            inv_done = 1'b1;
            inv_result = resp_tab[op];
            pend = 0;
          end
        end
      end
    end
  end

  // Compare process: checks every issue, every report and every end-of-run against the model queues.
  initial begin
    int cyc;
    int en_cyc;
    logic [W-1:0] cur_op;
    exp_t e;
    cyc = 0; en_cyc = 0; cur_op = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (inv_enable) begin
        check("issue_expected", issue_q.size() > 0, 1);
        if (issue_q.size() > 0) begin
          check("inv_t", inv_t, issue_q[0]);
          void'(issue_q.pop_front());
        end
        outst = 1;
        cur_op = inv_t;
        en_cyc = cyc;
      end else if (outst) begin
        check("inv_t_hold", inv_t, cur_op);
      end
      if (res_valid) begin
        check("busy_in_report", busy, 1);
        check("report_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("res_operand", res_operand, e.op);
          check("res_value", res_value, e.val);
          check("res_ok", res_ok, e.ok);
          check("res_skip", res_skip, e.skip);
          check("res_timeout", res_timeout, e.tmo);
          if (!e.skip) check("report_latency", cyc - en_cyc, e.lat);
        end
        outst = 0;
      end
      if (all_done) begin
        check("busy_at_done", busy, 0);
        check("err_count_at_done", err_count, model_err);
        check("reports_outstanding", exp_q.size(), 0);
        check("issues_outstanding", issue_q.size(), 0);
        done_seen++;
      end
    end
  end

  task automatic run(input int first, input int n, input int lat, input bit never, input bit poke);
    int d0;
    int b;
    model_err = 0;
    for (int k = 0; k < n; k++) begin
      int op;
      exp_t e;
      op = (first + k) % PV;
      e.op = op; e.val = 0; e.ok = 0; e.skip = 0; e.tmo = 0; e.lat = 0;
      if (op == 0) begin
        e.skip = 1;
      end else begin
        issue_q.push_back(W'(op));
        if (never) begin
          e.tmo = 1;
          e.lat = TMO + 1;
          if (model_err < 65535) model_err++;
        end else begin
          e.val = int'(resp_tab[op]);
          e.ok = (CHK == 0) || ((op * e.val) % PV == 1);
          e.lat = lat + 1 + CHK;
          if (!e.ok && model_err < 65535) model_err++;
        end
      end
      exp_q.push_back(e);
    end
    rsp_lat = lat;
    rsp_never = never;
    d0 = done_seen;
    @(negedge clk);
    first_val = W'(first);
    count = 16'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      check("zero_count_done_next_cycle", all_done, 1);
      check("zero_count_no_busy", busy, 0);
    end
    if (poke) begin
      repeat (3) @(negedge clk);
      first_val = W'(5);
      count = 16'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    b = 0;
    while (done_seen == d0 && b < 3000) begin
      @(negedge clk);
      b++;
    end
    check("run_completes", done_seen != d0, 1);
    @(negedge clk);
    check("single_all_done", done_seen - d0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; first_val = '0; count = '0;
    fill_good();
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    check("pin_inv1", resp_tab[1], 1);
    check("pin_inv2", resp_tab[2], 49);
    check("pin_inv3", resp_tab[3], 65);
    check("pin_inv4", resp_tab[4], 73);
    check("pin_inv96", resp_tab[96], 96);

    run(1, 4, 3, 0, 0);
    check("basic_err_count", err_count, 0);

    resp_tab[2] = W'(50);
    run(2, 1, 2, 0, 0);
    check("fault_err_count", err_count, FAULT_ERR);
    fill_good();

    run(96, 2, 1, 0, 0);
    check("wrap_err_count", err_count, 0);

    run(5, 1, 1, 1, 0);
    check("timeout_err_count", err_count, 1);

    run(10, 0, 1, 0, 0);
    check("zero_count_err_cleared", err_count, 0);

    run(20, 3, 2, 0, 1);

    rsp_stale = 1'b1;
    run(30, 3, 1, 0, 0);
    run(40, 2, 3, 0, 0);
    rsp_stale = 1'b0;

    // Abort a run while it waits for inv_done.
    rsp_never = 1'b1;
    issue_q.push_back(W'(7));
    @(negedge clk);
    first_val = W'(7);
    count = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_abort_busy", busy, 1);
    rst = 1'b1;
    exp_q.delete();
    issue_q.delete();
    outst = 0;
    @(negedge clk);
    check_idle("abort");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", all_done, 0);
    run(3, 1, 2, 0, 0);

    for (int r = 0; r < 12; r++) begin
      fill_random();
      rsp_stale = ($urandom_range(0, 2) == 0);
      run($urandom_range(0, PV - 1), $urandom_range(1, 6), $urandom_range(1, 6), 0, 0);
    end
    rsp_stale = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
